ad_capture: RTL and testbench

//  Serial ADC front end, one instance per analog channel (chN_cs_n/chN_sclk/chN_sdata pins of top).

---
 rtl/ad_capture.sv | 239 +++++++++++++++++++++++
 tb/tb_ad_capture.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ad_capture.sv
// ---------------------------------------------------------------------------
// ad_capture -- serial ADC front end for one AD7476-class channel.
//
// Frames a 16-bit read (LEAD_BITS leading zeros + DATA_W data bits, MSB
// first) every SAMPLE_PERIOD clk_sys cycles while en is high. Each captured
// sample is presented on dout with a one-cycle dout_vld strobe.
//
// Ports:
//   clk_sys    in   system clock
//   rst_n      in   asynchronous active-low reset
//   en         in   enable periodic conversion
//   cs_n       out  ADC chip select, active low
//   sclk       out  ADC serial clock, idles high
//   sdata      in   ADC serial data (ADC updates on sclk falling edge)
//   dout       out  last captured sample
//   dout_vld   out  one-cycle strobe, dout valid
//   frame_err  out  one-cycle strobe with dout_vld when a leading bit was 1
//   ovr        out  sticky: a period tick arrived while not idle
//   busy       out  high while a frame is in progress
//
// Configuration macro: AD_AVG_EN -- when defined, four consecutive frames
// are averaged (boxcar, truncating) and dout_vld fires once per four frames.
// ---------------------------------------------------------------------------
module ad_capture #(
  parameter int HALF_DIV      = 2,
  parameter int SAMPLE_PERIOD = 100,
  parameter int LEAD_BITS     = 4,
  parameter int DATA_W        = 12
) (
  input  logic              clk_sys,
  input  logic              rst_n,
  input  logic              en,
  output logic              cs_n,
  output logic              sclk,
  input  logic              sdata,
  output logic [DATA_W-1:0] dout,
  output logic              dout_vld,
  output logic              frame_err,
  output logic              ovr,
  output logic              busy
);

  localparam int FRAME = LEAD_BITS + DATA_W;
  localparam int CW    = $clog2(SAMPLE_PERIOD + 1);
  localparam int HW    = $clog2(HALF_DIV + 1);
  localparam int BW    = $clog2(FRAME + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [HW-1:0]     hcnt_q, hcnt_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [FRAME-1:0]  sreg_q, sreg_d;
  logic              cs_n_q, cs_n_d;
  logic              sclk_q, sclk_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              vld_q, vld_d;
  logic              ferr_q, ferr_d;
  logic              ovr_q, ovr_d;
  logic              busy_q, busy_d;

  logic tick;
  logic half_end;
  logic sample_err;

`ifdef AD_AVG_EN
  logic [DATA_W+1:0] acc_q, acc_d;
  logic [1:0]        ph_q, ph_d;
  logic              eacc_q, eacc_d;
  logic [DATA_W+1:0] avg_sum;

  assign avg_sum = acc_q + {2'b00, sreg_q[DATA_W-1:0]};
`endif

  assign tick       = en && (cnt_q == '0);
  assign half_end   = (hcnt_q == HW'(HALF_DIV - 1));
  assign sample_err = |sreg_q[FRAME-1:DATA_W];

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    bit_d   = bit_q;
    sreg_d  = sreg_q;
    cs_n_d  = cs_n_q;
    sclk_d  = sclk_q;
    dout_d  = dout_q;
    vld_d   = 1'b0;
    ferr_d  = 1'b0;
    ovr_d   = ovr_q;
    busy_d  = busy_q;
`ifdef AD_AVG_EN
    acc_d   = acc_q;
    ph_d    = ph_q;
    eacc_d  = eacc_q;
`endif

    // Period counter free-runs while enabled and parks at 0 otherwise, so
    // the first start happens the cycle after en is first seen high.
    if (!en) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(SAMPLE_PERIOD - 1)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    // Ticks that land outside IDLE (including DONE) are dropped and flagged.
    if (tick && (state_q != S_IDLE)) begin
      ovr_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (tick) begin
          state_d = S_SETUP;
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
          hcnt_d  = '0;
        end
      end
      S_SETUP: begin
        if (half_end) begin
          state_d = S_SHIFT;
          sclk_d  = 1'b0;
          hcnt_d  = '0;
          bit_d   = '0;
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
      S_SHIFT: begin
        if (!half_end) begin
          hcnt_d = hcnt_q + 1'b1;
        end else begin
          hcnt_d = '0;
          if (!sclk_q) begin
            // Capture on the cycle sclk is driven 0->1; data has been
            // stable since the previous falling edge.
            sclk_d = 1'b1;
            sreg_d = {sreg_q[FRAME-2:0], sdata};
          end else if (bit_q == BW'(FRAME - 1)) begin
            state_d = S_DONE;
            cs_n_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            bit_d  = bit_q + 1'b1;
            sclk_d = 1'b0;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
`ifdef AD_AVG_EN
        if (ph_q == 2'd3) begin
          dout_d = avg_sum[DATA_W+1:2];
          vld_d  = 1'b1;
          ferr_d = eacc_q | sample_err;
          acc_d  = '0;
          ph_d   = '0;
          eacc_d = 1'b0;
        end else begin
          acc_d  = avg_sum;
          ph_d   = ph_q + 1'b1;
          eacc_d = eacc_q | sample_err;
        end
`else
        dout_d = sreg_q[DATA_W-1:0];
        vld_d  = 1'b1;
        ferr_d = sample_err;
`endif
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

`ifdef AD_AVG_EN
    // Averaging restarts from an empty window whenever conversion is disabled.
    if (!en) begin
      acc_d  = '0;
      ph_d   = '0;
      eacc_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hcnt_q  <= '0;
      bit_q   <= '0;
      sreg_q  <= '0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b1;
      dout_q  <= '0;
      vld_q   <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
`ifdef AD_AVG_EN
      acc_q   <= '0;
      ph_q    <= '0;
      eacc_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hcnt_q  <= hcnt_d;
      bit_q   <= bit_d;
      sreg_q  <= sreg_d;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
      dout_q  <= dout_d;
      vld_q   <= vld_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
      busy_q  <= busy_d;
`ifdef AD_AVG_EN
      acc_q   <= acc_d;
      ph_q    <= ph_d;
      eacc_q  <= eacc_d;
`endif
    end
  end

  assign cs_n      = cs_n_q;
  assign sclk      = sclk_q;
  assign dout      = dout_q;
  assign dout_vld  = vld_q;
  assign frame_err = ferr_q;
  assign ovr       = ovr_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_ad_capture.sv
// ---------------------------------------------------------------------------
// tb_ad_capture -- directed self-checking bench for ad_capture.
// Instance u_dut uses default parameters and an ADC model; u_fast uses
// SAMPLE_PERIOD=50 to exercise dropped ticks and the sticky ovr flag.
// ---------------------------------------------------------------------------
module tb_ad_capture;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        en2 = 1'b0;
  logic        sdata = 1'b0;
  logic        sdata2 = 1'b0;
  logic [15:0] frame_word = 16'h0ABC;
  logic [4:0]  bitidx = 5'd15;

  logic        cs_n, sclk, dout_vld, frame_err, ovr, busy;
  logic [11:0] dout;
  logic        cs_n2, sclk2, dout_vld2, frame_err2, ovr2, busy2;
  logic [11:0] dout2;

  int vectors = 0;
  int miscompares = 0;

  // Monitor state (written only by the monitor processes)
  int   cyc = 0;
  int   cs_low_cnt = 0;
  int   cs_fall_cnt = 0;
  int   rise_cnt = 0;
  int   vld_cnt = 0;
  int   vld_last = 0;
  int   vld_prev = 0;
  int   vld2_cnt = 0;
  int   vld2_last = 0;
  int   vld2_prev = 0;
  int   bad_idle = 0;
  logic cs_prev = 1'b1;

  always #5 clk = ~clk;

  ad_capture u_dut (
    .clk_sys  (clk),
    .rst_n    (rst_n),
    .en       (en),
    .cs_n     (cs_n),
    .sclk     (sclk),
    .sdata    (sdata),
    .dout     (dout),
    .dout_vld (dout_vld),
    .frame_err(frame_err),
    .ovr      (ovr),
    .busy     (busy)
  );

  ad_capture #(.SAMPLE_PERIOD(50)) u_fast (
    .clk_sys  (clk),
    .rst_n    (rst_n),
    .en       (en2),
    .cs_n     (cs_n2),
    .sclk     (sclk2),
    .sdata    (sdata2),
    .dout     (dout2),
    .dout_vld (dout_vld2),
    .frame_err(frame_err2),
    .ovr      (ovr2),
    .busy     (busy2)
  );

  // ADC model: cs_n fall arms the MSB; each sclk fall presents the next bit.
  always @(negedge cs_n or negedge sclk) begin
    if (sclk) begin
      bitidx = 5'd15;
    end else if (!cs_n && !bitidx[4]) begin
      sdata  = frame_word[bitidx[3:0]];
      bitidx = bitidx - 5'd1;
    end
  end

  always @(posedge sclk) begin
    if (!cs_n) rise_cnt <= rise_cnt + 1;
  end

  // Samples pre-edge values, i.e. the state held during the previous cycle.
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    cs_prev <= cs_n;
    if (!cs_n) cs_low_cnt <= cs_low_cnt + 1;
    if (cs_prev && !cs_n) cs_fall_cnt <= cs_fall_cnt + 1;
    if (dout_vld) begin
      vld_cnt  <= vld_cnt + 1;
      vld_prev <= vld_last;
      vld_last <= cyc;
    end
    if (dout_vld2) begin
      vld2_cnt  <= vld2_cnt + 1;
      vld2_prev <= vld2_last;
      vld2_last <= cyc;
    end
    if ((cs_n && !sclk) || (cs_n2 && !sclk2)) bad_idle <= bad_idle + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
    $display("vector %0d %s: observed 0x%0h expected 0x%0h", vectors, tag, obs, exp);
  endtask

  // sel: 0 = dout_vld high, 1 = cs_n low, 2 = cs_n high
  task automatic wait_sig(input string tag, input int sel, input int budget);
    bit hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk);
      case (sel)
        0:       hit = dout_vld;
        1:       hit = !cs_n;
        default: hit = cs_n;
      endcase
    end
    check(tag, 32'(hit), 32'd1);
  endtask

  int base_vld, base_low, base_rise, base_fall, base_vld2, cyc0;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_cs_n", 32'(cs_n), 32'd1);
    check("rst_sclk", 32'(sclk), 32'd1);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_vld",  32'(dout_vld), 32'd0);
    check("rst_busy_ovr", 32'({busy, ovr, frame_err}), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

`ifndef AD_AVG_EN
    // 1: single frame of 0x0ABC
    base_vld  = vld_cnt;
    base_low  = cs_low_cnt;
    base_rise = rise_cnt;
    cyc0      = cyc;
    en = 1'b1;
    @(negedge clk);
    check("t1_cs_fall", 32'(cs_n), 32'd0);
    wait_sig("t1_vld_seen", 0, 100);
    check("t1_dout", 32'(dout), 32'h0ABC);
    check("t1_ferr", 32'(frame_err), 32'd0);
    check("t1_cs_low_cycles", 32'(cs_low_cnt - base_low), 32'd66);
    check("t1_sclk_rises", 32'(rise_cnt - base_rise), 32'd16);
    check("t1_cs_n_high", 32'(cs_n), 32'd1);
    check("t1_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("t1_vld_one_cycle", 32'(dout_vld), 32'd0);

    // 2: 1000 cycles of en -> 10 strobes, 100 apart
    while (cyc - cyc0 < 1000) @(negedge clk);
    check("t2_vld_count", 32'(vld_cnt - base_vld), 32'd10);
    check("t2_vld_spacing", 32'(vld_last - vld_prev), 32'd100);
    check("t2_ovr", 32'(ovr), 32'd0);

    // 3: leading-bit error still updates dout
    frame_word = 16'h8123;
    wait_sig("t3_vld_seen", 0, 150);
    check("t3_dout", 32'(dout), 32'h123);
    check("t3_ferr", 32'(frame_err), 32'd1);

    // 4: en dropped at cycle 30 of a frame
    frame_word = 16'h0555;
    wait_sig("t4_cs_fall", 1, 150);
    repeat (29) @(negedge clk);
    check("t4_busy_mid", 32'({busy, cs_n}), 32'b10);
    en = 1'b0;
    base_vld  = vld_cnt;
    base_fall = cs_fall_cnt;
    repeat (300) @(negedge clk);
    check("t4_vld_once", 32'(vld_cnt - base_vld), 32'd1);
    check("t4_dout", 32'(dout), 32'h555);
    check("t4_no_restart", 32'(cs_fall_cnt - base_fall), 32'd0);
    check("t4_cs_n_idle", 32'(cs_n), 32'd1);

    // 5: reset at cycle 40 of a frame
    frame_word = 16'h0ABC;
    en = 1'b1;
    wait_sig("t5_cs_fall", 1, 10);
    repeat (39) @(negedge clk);
    base_vld = vld_cnt;
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_cs_n", 32'(cs_n), 32'd1);
    check("t5_rst_sclk", 32'(sclk), 32'd1);
    check("t5_rst_dout", 32'(dout), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_restart", 32'(cs_n), 32'd0);
    check("t5_no_vld", 32'(vld_cnt - base_vld), 32'd0);
    wait_sig("t5_vld_seen", 0, 100);
    check("t5_dout", 32'(dout), 32'h0ABC);
    en = 1'b0;
    repeat (2) @(negedge clk);

    // 6: SAMPLE_PERIOD=50 drops every other tick
    base_vld2 = vld2_cnt;
    en2 = 1'b1;
    repeat (10) @(negedge clk);
    check("t6_ovr_clear_early", 32'(ovr2), 32'd0);
    repeat (390) @(negedge clk);
    check("t6_ovr_set", 32'(ovr2), 32'd1);
    check("t6_vld_count", 32'(vld2_cnt - base_vld2), 32'd4);
    check("t6_vld_spacing", 32'(vld2_last - vld2_prev), 32'd100);
    check("t6_fast_data", 32'({dout2, frame_err2, busy2}), 32'd0);
    check("t6_main_ovr", 32'(ovr), 32'd0);
    en2 = 1'b0;
`else
    // 7: boxcar of four samples
    frame_word = 16'h0100;
    base_vld = vld_cnt;
    en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_sig("t7_cs_fall", 1, 150);
      wait_sig("t7_cs_rise", 2, 100);
      frame_word = 16'((k + 2) * 256);
    end
    wait_sig("t7_vld_seen", 0, 10);
    check("t7_dout", 32'(dout), 32'h280);
    check("t7_ferr", 32'(frame_err), 32'd0);
    check("t7_vld_once", 32'(vld_cnt - base_vld), 32'd1);
    en = 1'b0;
`endif

    repeat (5) @(negedge clk);
    check("sclk_idle_high", 32'(bad_idle), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
